// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Register indices are zero-extended to MAX_REG_ADDR_W inside the shadow pipeline.
package pipe_hazard_pkg;

    localparam int MAX_REG_ADDR_W = 8;
    localparam int FWD_RF         = 0;

    typedef struct packed {
        logic                      valid;
        logic                      wb_en;
        logic                      is_load;
        logic                      uses1;
        logic                      uses2;
        logic [MAX_REG_ADDR_W-1:0] rd;
        logic [MAX_REG_ADDR_W-1:0] rs1;
        logic [MAX_REG_ADDR_W-1:0] rs2;
    } stage_info_t;

    function automatic int fwdSelWidth(input int numStages);
        return $clog2(numStages - 2);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding priority encoder for one EX operand: the youngest producer whose
// result is already available wins; otherwise the register file is selected.
module pipe_fwd_sel
    import pipe_hazard_pkg::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int LOAD_READY_STG = 4,
    parameter int SEL_W          = fwdSelWidth(NUM_STAGES)
) (
    input  stage_info_t [NUM_STAGES-3:0] i_stages,
    input  logic [MAX_REG_ADDR_W-1:0]    i_src,
    input  logic                         i_uses,
    output logic [SEL_W-1:0]             o_sel
);

    logic w_unused;
    assign w_unused = ^i_stages;

    // Scan oldest to youngest so the youngest (lowest stage) match is the last write.
    always_comb begin
        o_sel = SEL_W'(FWD_RF);
        if (i_uses && (i_src != '0)) begin
            for (int k = NUM_STAGES - 3; k >= 1; k--) begin
                if (i_stages[k].valid && i_stages[k].wb_en && (i_stages[k].rd == i_src) &&
                    (!i_stages[k].is_load || ((k + 2) >= LOAD_READY_STG))) begin
                    o_sel = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shadows stages EX..WB, derives stall/flush/bubble
// and operand forwarding selects, and counts retired instructions.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int LOAD_READY_STG = 4,
    parameter int REG_ADDR_W     = 5,
    parameter int CNT_W          = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  id_valid_i,
    input  logic [REG_ADDR_W-1:0]                 id_rs1_i,
    input  logic [REG_ADDR_W-1:0]                 id_rs2_i,
    input  logic                                  id_uses_rs1_i,
    input  logic                                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0]                 id_rd_i,
    input  logic                                  id_wb_en_i,
    input  logic                                  id_is_load_i,
    input  logic                                  ex_redirect_i,
    input  logic                                  mem_stall_i,
    output logic                                  stall_if_o,
    output logic                                  stall_id_o,
    output logic                                  flush_id_o,
    output logic                                  bubble_ex_o,
    output logic [fwdSelWidth(NUM_STAGES)-1:0]    fwd_a_sel_o,
    output logic [fwdSelWidth(NUM_STAGES)-1:0]    fwd_b_sel_o,
    output logic [NUM_STAGES-3:0]                 stage_valid_o,
    output logic [CNT_W-1:0]                      instret_o
);

    localparam int SHADOW_N = NUM_STAGES - 2;
    localparam int SEL_W    = fwdSelWidth(NUM_STAGES);

    stage_info_t [SHADOW_N-1:0]  r_stages;
    logic [CNT_W-1:0]            r_instret;
    stage_info_t                 w_idInfo;
    stage_info_t                 w_exEntry;
    logic [MAX_REG_ADDR_W-1:0]   w_idRs1;
    logic [MAX_REG_ADDR_W-1:0]   w_idRs2;
    logic                        w_loadUse;
    logic                        w_stall;
    logic                        w_flush;
    logic                        w_bubble;
    logic [SEL_W-1:0]            w_fwdA;
    logic [SEL_W-1:0]            w_fwdB;

    assign w_idRs1 = MAX_REG_ADDR_W'(id_rs1_i);
    assign w_idRs2 = MAX_REG_ADDR_W'(id_rs2_i);

    always_comb begin
        w_idInfo         = '0;
        w_idInfo.valid   = 1'b1;
        w_idInfo.wb_en   = id_wb_en_i;
        w_idInfo.is_load = id_is_load_i;
        w_idInfo.uses1   = id_uses_rs1_i;
        w_idInfo.uses2   = id_uses_rs2_i;
        w_idInfo.rd      = MAX_REG_ADDR_W'(id_rd_i);
        w_idInfo.rs1     = w_idRs1;
        w_idInfo.rs2     = w_idRs2;
    end

    // Only loads that cannot reach EX in time via forwarding force a stall.
    always_comb begin
        w_loadUse = 1'b0;
        for (int k = 0; k <= LOAD_READY_STG - 4; k++) begin
            if (r_stages[k].valid && r_stages[k].wb_en && r_stages[k].is_load &&
                (r_stages[k].rd != '0)) begin
                if ((id_uses_rs1_i && (r_stages[k].rd == w_idRs1)) ||
                    (id_uses_rs2_i && (r_stages[k].rd == w_idRs2))) begin
                    w_loadUse = 1'b1;
                end
            end
        end
        w_loadUse = w_loadUse & id_valid_i;
    end

    always_comb begin
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        if (!rst) begin
            if (mem_stall_i) begin
                w_stall = 1'b1;
            end else if (ex_redirect_i) begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
            end else if (w_loadUse) begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        w_exEntry = '0;
        if (id_valid_i && !w_bubble) begin
            w_exEntry = w_idInfo;
        end
    end

    pipe_fwd_sel #(
        .NUM_STAGES     (NUM_STAGES),
        .LOAD_READY_STG (LOAD_READY_STG),
        .SEL_W          (SEL_W)
    ) u_fwdA (
        .i_stages (r_stages),
        .i_src    (r_stages[0].rs1),
        .i_uses   (r_stages[0].valid & r_stages[0].uses1),
        .o_sel    (w_fwdA)
    );

    pipe_fwd_sel #(
        .NUM_STAGES     (NUM_STAGES),
        .LOAD_READY_STG (LOAD_READY_STG),
        .SEL_W          (SEL_W)
    ) u_fwdB (
        .i_stages (r_stages),
        .i_src    (r_stages[0].rs2),
        .i_uses   (r_stages[0].valid & r_stages[0].uses2),
        .o_sel    (w_fwdB)
    );

    assign stall_if_o  = w_stall;
    assign stall_id_o  = w_stall;
    assign flush_id_o  = w_flush;
    assign bubble_ex_o = w_bubble;
    assign fwd_a_sel_o = rst ? '0 : w_fwdA;
    assign fwd_b_sel_o = rst ? '0 : w_fwdB;
    assign instret_o   = rst ? '0 : r_instret;

    always_comb begin
        stage_valid_o = '0;
        if (!rst) begin
            for (int k = 0; k < SHADOW_N; k++) begin
                stage_valid_o[k] = r_stages[k].valid;
            end
        end
    end

    // A memory stall freezes the shadow pipe and the counter together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stages  <= '0;
            r_instret <= '0;
        end else if (!mem_stall_i) begin
            if (r_stages[SHADOW_N-1].valid) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            r_stages <= {r_stages[SHADOW_N-2:0], w_exEntry};
        end
    end

endmodule
